keypad_scan_ctrl: RTL

Sequencing controller for the 4x4 hex keypad. It drives the active-low row selects, samples the synchronized column inputs, and debounces both press and release. It emits one registered key code with a single-cycle valid strobe per accepted press. It sits between the column synchronizer and the digit-history/seven-segment display logic in `top`.

---
 rtl/keypad_pkg.sv | 59 +++++
 rtl/kp_debounce_cnt.sv | 29 ++
 rtl/keypad_scan_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 hex keypad scanner.
// Holds the controller state enum, the row-drive pattern and the key legend.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    localparam logic [3:0] ROW0_DRIVE = 4'b1110;

    // Active-low row select: the row-0 pattern rotated left by the row index.
    function automatic logic [3:0] row_drive(input logic [1:0] row);
        logic [3:0] drive;
        case (row)
            2'd0:    drive = ROW0_DRIVE;
            2'd1:    drive = {ROW0_DRIVE[2:0], ROW0_DRIVE[3]};
            2'd2:    drive = {ROW0_DRIVE[1:0], ROW0_DRIVE[3:2]};
            default: drive = {ROW0_DRIVE[0], ROW0_DRIVE[3:1]};
        endcase
        return drive;
    endfunction

    // Lowest-index column reading 0; only meaningful when some column is low.
    function automatic logic [1:0] first_low_col(input logic [3:0] cols);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/kp_debounce_cnt.sv
// Saturating stability counter with synchronous clear and enable.
// done is high while the count equals N; the count never wraps.
module kp_debounce_cnt #(
    parameter int N = 8,
    parameter int W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         done
);

    assign done = (count == W'(N));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values and simulation ordering cannot change results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !done) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning keypad controller with press/release debounce and a
// single-cycle key_valid strobe. Define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] col_sync,
    output logic [3:0] r_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DWELL_W = $clog2(SCAN_DIV) + 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;

    if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("keypad_scan_ctrl: SCAN_DIV must be >= 2, other periods >= 1");
    end

    kp_state_e          state, state_next;
    logic [1:0]         row, row_next;
    logic [1:0]         col_idx, col_idx_next;
    logic [DWELL_W-1:0] dwell, dwell_next;
    logic [3:0]         key_code_next;
    logic               key_valid_next;

    logic               db_clr, db_en, db_done;
    logic [DB_W-1:0]    db_count;
    logic               col_pressed;
    logic               db_last;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
    logic [RPT_W-1:0]   rpt_cnt, rpt_next;
`endif

    // Only the latched column of the frozen row is ever observed after a hit.
    assign col_pressed = ~col_sync[col_idx];
    assign db_last     = (db_count == DB_W'(DEBOUNCE_CYCLES - 1));
    assign key_held    = (state == HELD) || (state == RELEASE);

    kp_debounce_cnt #(
        .N (DEBOUNCE_CYCLES),
        .W (DB_W)
    ) u_debounce_cnt (
        .clk   (int_osc),
        .rst_n (reset),
        .clr   (db_clr),
        .en    (db_en),
        .count (db_count),
        .done  (db_done)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        row_next       = row;
        col_idx_next   = col_idx;
        dwell_next     = dwell;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        db_clr         = 1'b0;
        db_en          = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_next       = '0;
`endif

        unique case (state)
            SCAN: begin
                db_clr = 1'b1;
                if (col_sync != 4'hF) begin
                    state_next   = DEBOUNCE;
                    col_idx_next = first_low_col(col_sync);
                    dwell_next   = '0;
                end else if (dwell == DWELL_W'(SCAN_DIV - 1)) begin
                    dwell_next = '0;
                    row_next   = row + 2'd1;
                end else begin
                    dwell_next = dwell + DWELL_W'(1);
                end
            end

            DEBOUNCE: begin
                if (db_done) begin
                    state_next = HELD;
                end else if (col_pressed) begin
                    db_en = 1'b1;
                    // Load one cycle early so code and strobe appear as the count lands on N.
                    if (db_last) begin
                        key_code_next  = key_map(row, col_idx);
                        key_valid_next = 1'b1;
                    end
                end else begin
                    db_clr     = 1'b1;
                    state_next = SCAN;
                    row_next   = row + 2'd1;
                end
            end

            HELD: begin
                db_clr = 1'b1;
                if (!col_pressed) begin
                    state_next = RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1)) begin
                    key_valid_next = 1'b1;
                end else begin
                    rpt_next = rpt_cnt + RPT_W'(1);
                end
`endif
            end

            RELEASE: begin
                if (db_done) begin
                    db_clr     = 1'b1;
                    state_next = SCAN;
                    row_next   = row + 2'd1;
                end else if (!col_pressed) begin
                    db_en = 1'b1;
                end else begin
                    db_clr     = 1'b1;
                    state_next = HELD;
                end
            end
        endcase
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            row       <= '0;
            col_idx   <= '0;
            dwell     <= '0;
            r_sel     <= ROW0_DRIVE;
            key_code  <= '0;
            key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            state     <= state_next;
            row       <= row_next;
            col_idx   <= col_idx_next;
            dwell     <= dwell_next;
            r_sel     <= row_drive(row_next);
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt   <= rpt_next;
`endif
        end
    end

endmodule
